// File: rtl/uart_core_param_if.sv
// uart_core_param_if: host-side TX/RX valid/ready channels.
// master = host/game logic, slave = the UART core.
interface uart_core_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART, 16x oversampled RX, RX FIFO.
// Optional parity (PARITY state, rx_parity_err) under `UART_PARITY_EN.
module uart_core_param #(
  parameter int CLK_HZ        = 50000000,
  parameter int BAUD          = 115200,
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
`ifdef UART_PARITY_EN
  ,
  parameter bit PARITY_ODD    = 1'b0
`endif
) (
  input  logic             clk,
  input  logic             reset_pin,
  input  logic             rx,
  output logic             tx,
  uart_core_param_if.slave bus,
  output logic             rx_busy,
  output logic             tx_busy,
  output logic             rx_frame_err,
  output logic             rx_overrun
`ifdef UART_PARITY_EN
  ,
  output logic             rx_parity_err
`endif
);

  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int DW  = $clog2(DIV + 1);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int AW  = $clog2(RX_FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } st_t;

  // ---------------- TX ----------------
  st_t                  tst_q, tst_d;
  logic [DW-1:0]        tdiv_q, tdiv_d;
  logic [3:0]           tcnt_q, tcnt_d;
  logic [BW-1:0]        tbit_q, tbit_d;
  logic                 tstop_q, tstop_d;
  logic [DATA_BITS-1:0] tsh_q, tsh_d;
  logic                 ton_q, ton_d;
  logic                 tx_q, tx_d;
`ifdef UART_PARITY_EN
  logic                 tpar_q, tpar_d;
`endif
  logic                 ttick, tend;

  assign ttick = (tdiv_q == DW'(DIV - 1));
  assign tend  = ttick && ton_q && (tcnt_q == 4'd15);

  // TX next state: wait for first tick, then 16 ticks per bit
  always_comb begin
    tst_d   = tst_q;
    tcnt_d  = tcnt_q;
    tbit_d  = tbit_q;
    tstop_d = tstop_q;
    tsh_d   = tsh_q;
    ton_d   = ton_q;
    tx_d    = tx_q;
    tdiv_d  = ttick ? '0 : tdiv_q + DW'(1);
`ifdef UART_PARITY_EN
    tpar_d  = tpar_q;
`endif
    if (ttick && ton_q) tcnt_d = tcnt_q + 4'd1;
    unique case (tst_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (bus.tx_valid) begin
          tst_d   = S_START;
          tsh_d   = bus.tx_data;
          ton_d   = 1'b0;
          tcnt_d  = '0;
          tbit_d  = '0;
          tstop_d = 1'b0;
`ifdef UART_PARITY_EN
          tpar_d  = (^bus.tx_data) ^ PARITY_ODD;
`endif
        end
      end
      S_START: begin
        if (ttick && !ton_q) begin
          ton_d = 1'b1;
          tx_d  = 1'b0;
        end else if (tend) begin
          tst_d = S_DATA;
          tx_d  = tsh_q[0];
        end
      end
      S_DATA: begin
        if (tend) begin
          if (tbit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            tst_d = S_PAR;
            tx_d  = tpar_q;
`else
            tst_d = S_STOP;
            tx_d  = 1'b1;
`endif
          end else begin
            tbit_d = tbit_q + BW'(1);
            tsh_d  = tsh_q >> 1;
            tx_d   = tsh_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: begin
        if (tend) begin
          tst_d = S_STOP;
          tx_d  = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (tend) begin
          if (tstop_q == 1'(STOP_BITS - 1)) tst_d = S_IDLE;
          else tstop_d = 1'b1;
        end
      end
      default: begin
        tst_d = S_IDLE;
        tx_d  = 1'b1;
      end
    endcase
  end

  // TX registers; tx goes high at once on reset
  always_ff @(posedge clk or negedge reset_pin) begin
    if (!reset_pin) begin
      tst_q   <= S_IDLE;
      tdiv_q  <= '0;
      tcnt_q  <= '0;
      tbit_q  <= '0;
      tstop_q <= 1'b0;
      tsh_q   <= '0;
      ton_q   <= 1'b0;
      tx_q    <= 1'b1;
`ifdef UART_PARITY_EN
      tpar_q  <= 1'b0;
`endif
    end else begin
      tst_q   <= tst_d;
      tdiv_q  <= tdiv_d;
      tcnt_q  <= tcnt_d;
      tbit_q  <= tbit_d;
      tstop_q <= tstop_d;
      tsh_q   <= tsh_d;
      ton_q   <= ton_d;
      tx_q    <= tx_d;
`ifdef UART_PARITY_EN
      tpar_q  <= tpar_d;
`endif
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = (tst_q != S_IDLE);
  assign bus.tx_ready = ~tx_busy;

  // ---------------- RX ----------------
  st_t                  rst_q, rst_d;
  logic                 rxm_q, rxs_q, rxp_q;
  logic [DW-1:0]        rdiv_q, rdiv_d;
  logic [3:0]           rcnt_q, rcnt_d;
  logic [BW-1:0]        rbit_q, rbit_d;
  logic [DATA_BITS-1:0] rsh_q, rsh_d;
  logic [1:0]           rv_q, rv_d;
  logic                 rbrk_q, rbrk_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_PARITY_EN
  logic                 rpe_q, rpe_d;
  logic                 perr_q, perr_d;
`endif
  logic                 rtick, rmid, rend, vote, rwr;

  assign rtick = (rdiv_q == DW'(DIV - 1));
  assign rmid  = rtick && (rcnt_q == 4'd8);
  assign rend  = rtick && (rcnt_q == 4'd15);
  assign vote  = (rv_q[0] & rv_q[1]) | (rv_q[0] & rxs_q) |
                 (rv_q[1] & rxs_q);

  // RX next state: vote ticks 7/8/9, decide on tick 9
  always_comb begin
    rst_d  = rst_q;
    rcnt_d = rcnt_q;
    rbit_d = rbit_q;
    rsh_d  = rsh_q;
    rv_d   = rv_q;
    rbrk_d = rbrk_q;
    rdiv_d = rtick ? '0 : rdiv_q + DW'(1);
    ferr_d = 1'b0;
    rwr    = 1'b0;
`ifdef UART_PARITY_EN
    rpe_d  = rpe_q;
    perr_d = 1'b0;
`endif
    if (rtick) rcnt_d = rcnt_q + 4'd1;
    if (rtick && rcnt_q == 4'd6) rv_d[0] = rxs_q;
    if (rtick && rcnt_q == 4'd7) rv_d[1] = rxs_q;
    unique case (rst_q)
      S_IDLE: begin
        rcnt_d = '0;
        rbrk_d = 1'b0;
        if (rxp_q && !rxs_q) begin
          rst_d  = S_START;
          rdiv_d = '0;
        end
      end
      S_START: begin
        if (rmid && vote) begin
          rst_d = S_IDLE;
        end else if (rend) begin
          rst_d  = S_DATA;
          rbit_d = '0;
        end
      end
      S_DATA: begin
        if (rmid) rsh_d = {vote, rsh_q[DATA_BITS-1:1]};
        if (rend) begin
          if (rbit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            rst_d = S_PAR;
`else
            rst_d = S_STOP;
`endif
          end else begin
            rbit_d = rbit_q + BW'(1);
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: begin
        if (rmid) rpe_d = vote ^ (^rsh_q) ^ PARITY_ODD;
        if (rend) rst_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (rbrk_q) begin
          if (rxs_q) rst_d = S_IDLE;
        end else if (rmid) begin
`ifdef UART_PARITY_EN
          perr_d = rpe_q;
`endif
          if (vote) begin
            rst_d = S_IDLE;
`ifdef UART_PARITY_EN
            rwr   = ~rpe_q;
`else
            rwr   = 1'b1;
`endif
          end else begin
            ferr_d = 1'b1;
            rbrk_d = 1'b1;
          end
        end
      end
      default: rst_d = S_IDLE;
    endcase
  end

  // RX registers and 2-flop synchroniser
  always_ff @(posedge clk or negedge reset_pin) begin
    if (!reset_pin) begin
      rxm_q  <= 1'b1;
      rxs_q  <= 1'b1;
      rxp_q  <= 1'b1;
      rst_q  <= S_IDLE;
      rdiv_q <= '0;
      rcnt_q <= '0;
      rbit_q <= '0;
      rsh_q  <= '0;
      rv_q   <= 2'b11;
      rbrk_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_PARITY_EN
      rpe_q  <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      rxm_q  <= rx;
      rxs_q  <= rxm_q;
      rxp_q  <= rxs_q;
      rst_q  <= rst_d;
      rdiv_q <= rdiv_d;
      rcnt_q <= rcnt_d;
      rbit_q <= rbit_d;
      rsh_q  <= rsh_d;
      rv_q   <= rv_d;
      rbrk_q <= rbrk_d;
      ferr_q <= ferr_d;
`ifdef UART_PARITY_EN
      rpe_q  <= rpe_d;
      perr_q <= perr_d;
`endif
    end
  end

  assign rx_busy      = (rst_q != S_IDLE);
  assign rx_frame_err = ferr_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = perr_q;
`endif

  // ---------------- RX FIFO ----------------
  logic [AW:0]          wp_q, wp_d, rp_q, rp_d;
  logic [DATA_BITS-1:0] mem_q [RX_FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [RX_FIFO_DEPTH];
  logic                 ovr_q, ovr_d;
  logic                 empty, full, pop, push;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop   = ~empty & bus.rx_ready;
  assign push  = rwr & (~full | pop);

  // FIFO update: a pop in the same cycle frees room for a write
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    ovr_d = ovr_q | (rwr & full & ~pop);
    if (push) begin
      mem_d[wp_q[AW-1:0]] = rsh_q;
      wp_d = wp_q + (AW+1)'(1);
    end
    if (pop) rp_d = rp_q + (AW+1)'(1);
  end

  // FIFO storage, pointers and sticky overrun
  always_ff @(posedge clk or negedge reset_pin) begin
    if (!reset_pin) begin
      for (int i = 0; i < RX_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovr_q <= ovr_d;
    end
  end

  assign bus.rx_valid = ~empty;
  assign bus.rx_data  = empty ? '0 : mem_q[rp_q[AW-1:0]];
  assign rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: table-driven RX frames, TX line checks,
// loopback scoreboard, overrun, break/glitch and async reset.
module tb_uart_core_param;

  localparam int DIV    = 27;
  localparam int BITC   = 432;
  localparam int BIT_NS = 8640;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 10 + PB;

  typedef struct packed {
    logic [7:0] d;
    logic       stop;
    logic       exp_wr;
    logic       exp_ferr;
  } rxv_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rx_drv = 1'b1;
  logic loop = 1'b0;
  logic rx_line, tx_w, rx_busy, tx_busy, ferr, ovr;
  int   pass_n = 0;
  int   tot_n = 0;
  int   ferr_cnt = 0;
  logic [7:0] sb[$];
`ifdef UART_PARITY_EN
  logic perr;
  int   perr_cnt = 0;
`endif

  uart_core_param_if #(.DATA_BITS(8)) bus ();

  assign rx_line = loop ? tx_w : rx_drv;

  uart_core_param #(
    .CLK_HZ(50000000),
    .BAUD(115200),
    .DATA_BITS(8),
    .STOP_BITS(1),
    .RX_FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset_pin(rst_n),
    .rx(rx_line),
    .tx(tx_w),
    .bus(bus),
    .rx_busy(rx_busy),
    .tx_busy(tx_busy),
    .rx_frame_err(ferr),
    .rx_overrun(ovr)
`ifdef UART_PARITY_EN
    ,
    .rx_parity_err(perr)
`endif
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (ferr) ferr_cnt <= ferr_cnt + 1;
`ifdef UART_PARITY_EN
  always @(posedge clk) if (perr) perr_cnt <= perr_cnt + 1;
`endif

  initial begin
    #1900000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_drv = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      #(BIT_NS);
    end
`ifdef UART_PARITY_EN
    rx_drv = ^d;
    #(BIT_NS);
`endif
    rx_drv = stop;
    #(BIT_NS);
    rx_drv = 1'b1;
  endtask

`ifdef UART_PARITY_EN
  task automatic send_bad_par(input logic [7:0] d);
    rx_drv = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      #(BIT_NS);
    end
    rx_drv = ~(^d);
    #(BIT_NS);
    rx_drv = 1'b1;
    #(BIT_NS);
  endtask
`endif

  task automatic drain(input string tag);
    logic [7:0] e;
    int w;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      w = 0;
      while (!bus.rx_valid && w < 2 * NB * BITC) begin
        @(negedge clk);
        w++;
      end
      chk({tag, "_valid"}, bus.rx_valid, 1);
      chk({tag, "_data"}, bus.rx_data, e);
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
    end
    chk({tag, "_empty"}, bus.rx_valid, 0);
  endtask

  task automatic tx_check(input logic [7:0] d);
    logic [NB-1:0] fb;
    int w, k, rise_at, blen;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = d[i];
`ifdef UART_PARITY_EN
    fb[NB-2] = ^d;
`endif
    fb[NB-1] = 1'b1;
    k = NB - 1;
    for (int i = NB - 1; i >= 1; i--) if (fb[i]) k = i;
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    chk("tx_ready_low", bus.tx_ready, 0);
    chk("tx_busy_high", tx_busy, 1);
    blen = 1;
    w = 0;
    while (tx_w && w < 2 * DIV) begin
      @(negedge clk);
      w++;
      if (tx_busy) blen++;
    end
    chk("tx_start", tx_w, 0);
    rise_at = -1;
    for (int c = 0; c < NB * BITC; c++) begin
      if (c % BITC == BITC / 2)
        chk($sformatf("tx_bit%0d", c / BITC), tx_w, fb[c / BITC]);
      if (rise_at < 0 && tx_w) rise_at = c;
      @(negedge clk);
      if (tx_busy) blen++;
    end
    w = 0;
    while (tx_busy && w < 4 * DIV) begin
      @(negedge clk);
      w++;
      if (tx_busy) blen++;
    end
    chk("tx_first_rise", rise_at, k * BITC);
    chk("tx_busy_len", (blen >= NB * BITC) && (blen <= NB * BITC + DIV), 1);
    chk("tx_ready_back", bus.tx_ready, 1);
    chk("tx_idle", tx_w, 1);
  endtask

  initial begin
    rxv_t tv[4];
    logic [7:0] d;
    int f0;
    tv[0] = '{8'hAB, 1'b1, 1'b1, 1'b0};
    tv[1] = '{8'hAC, 1'b1, 1'b1, 1'b0};
    tv[2] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    tv[3] = '{8'h96, 1'b1, 1'b1, 1'b0};
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;

    #1 rst_n = 1'b0;
    #14;
    chk("rst_tx", tx_w, 1);
    chk("rst_tx_ready", bus.tx_ready, 1);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_rx_busy", rx_busy, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);
    #5 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      f0 = ferr_cnt;
      send_frame(tv[i].d, tv[i].stop);
      if (tv[i].exp_wr) sb.push_back(tv[i].d);
      #9000;
      @(negedge clk);
      chk($sformatf("rx%0d_ferr", i), ferr_cnt - f0, tv[i].exp_ferr);
      chk($sformatf("rx%0d_valid", i), bus.rx_valid, sb.size() != 0);
      chk($sformatf("rx%0d_head", i), bus.rx_data, sb[0]);
      chk($sformatf("rx%0d_busy", i), rx_busy, 0);
    end

    f0 = ferr_cnt;
    rx_drv = 1'b0;
    #200;
    rx_drv = 1'b1;
    @(negedge clk);
    chk("glitch_busy", rx_busy, 1);
    #(BIT_NS);
    @(negedge clk);
    chk("glitch_idle", rx_busy, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    drain("fifo");

    loop = 1'b1;
    sb.push_back(8'h5A);
    tx_check(8'h5A);
    drain("loop");
    loop = 1'b0;

    for (int i = 0; i < 5; i++) begin
      d = 8'h11 * 8'(i + 1);
      send_frame(d, 1'b1);
      if (i < 4) sb.push_back(d);
      #2000;
      @(negedge clk);
      chk($sformatf("ovr_after%0d", i), ovr, i >= 4);
    end
    drain("ovr");
    chk("ovr_sticky", ovr, 1);

    @(negedge clk);
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (1000) @(negedge clk);
    chk("mid_tx_low", tx_w, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("areset_tx", tx_w, 1);
    chk("areset_busy", tx_busy, 0);
    chk("areset_ovr", ovr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

`ifdef UART_PARITY_EN
    loop = 1'b1;
    sb.push_back(8'h07);
    tx_check(8'h07);
    drain("par");
    loop = 1'b0;
    f0 = perr_cnt;
    send_bad_par(8'h07);
    @(negedge clk);
    chk("perr_pulse", perr_cnt - f0, 1);
    chk("perr_nowrite", bus.rx_valid, 0);
`endif

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
